// File: rtl/sigmoid_interp_scheduler.sv
// rtl/sigmoid_interp_scheduler.sv - round-robin sharing of one sigmoid LUT and interpolator among lanes
module sigmoid_interp_scheduler #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int FRAC = 4,
    parameter int AW   = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DW-1:0]       req_x,
    output logic [NREQ-1:0]          gnt,
    output logic                     lut_en,
    output logic [AW-1:0]            lut_addr,
    input  logic [DW-1:0]            lut_data,
    output logic [DW-1:0]            ip_base,
    output logic [DW-1:0]            ip_next,
    output logic [DW-1:0]            ip_change,
    output logic [DW-1:0]            ip_remaining,
    input  logic [DW-1:0]            ip_value,
    output logic                     out_valid,
    output logic [$clog2(NREQ)-1:0]  out_lane,
    output logic [DW-1:0]            out_value,
    input  logic                     out_ready
);
    localparam int LW = $clog2(NREQ);

    typedef enum logic [2:0] {IDLE, RD_BASE, RD_NEXT, WAIT, CALC, RESP} state_t;

    state_t            state, state_nx;
    logic [LW-1:0]     rr_ptr;
    logic [LW-1:0]     lane;
    logic [LW-1:0]     winner;
    logic              found;
    logic [DW-1:0]     x_sel;
    logic [AW-1:0]     idx_sel;
    logic [FRAC-1:0]   frac_q;
    logic [DW-1:0]     base_q;

    // Search starts just after the last winner so every lane gets its turn.
    always_comb begin
        winner = rr_ptr;
        found  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req[LW'((int'(rr_ptr) + k) % NREQ)]) begin
                winner = LW'((int'(rr_ptr) + k) % NREQ);
                found  = 1'b1;
            end
        end
    end

    // Adding half the table span to the signed integer part is an MSB flip.
    always_comb begin
        x_sel   = req_x[winner*DW +: DW];
        idx_sel = AW'({~x_sel[DW-1], x_sel[DW-2:FRAC]});
    end

    always_comb begin
        state_nx = state;
        gnt      = '0;
        lut_en   = 1'b0;
        case (state)
            IDLE:    if (found) state_nx = RD_BASE;
            RD_BASE: begin
                gnt[lane] = 1'b1;
                lut_en    = 1'b1;
                state_nx  = RD_NEXT;
            end
            RD_NEXT: begin
                lut_en   = 1'b1;
                state_nx = WAIT;
            end
            WAIT:    state_nx = CALC;
            CALC:    state_nx = RESP;
            RESP:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= LW'(NREQ - 1);
            lane         <= '0;
            frac_q       <= '0;
            base_q       <= '0;
            lut_addr     <= '0;
            ip_base      <= '0;
            ip_next      <= '0;
            ip_change    <= '0;
            ip_remaining <= '0;
            out_valid    <= 1'b0;
            out_lane     <= '0;
            out_value    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (found) begin
                    lane     <= winner;
                    rr_ptr   <= winner;
                    frac_q   <= x_sel[FRAC-1:0];
                    lut_addr <= idx_sel;
                end
                RD_BASE: lut_addr <= lut_addr + 1'b1;
                RD_NEXT: base_q <= lut_data;
                WAIT: begin
                    ip_base      <= base_q;
                    ip_next      <= lut_data;
                    ip_change    <= lut_data - base_q;
                    ip_remaining <= DW'(frac_q);
                end
                CALC: begin
                    out_value <= ip_value;
                    out_lane  <= lane;
                    out_valid <= 1'b1;
                end
                RESP: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule
